// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM width sequencer: state encoding, data width
// and the gamma curve used when PWM_SEQ_GAMMA_EN is defined.
package pwm_seq_pkg;

    localparam int unsigned WIDTH_W = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StUp     = 3'd1,
        StHoldHi = 3'd2,
        StDown   = 3'd3,
        StHoldLo = 3'd4
    } seq_state_e;

    // Perceptual curve: (lvl*lvl + 255) >> 8, keeps 0->0 and 255->255.
    function automatic logic [WIDTH_W-1:0] gamma(input logic [WIDTH_W-1:0] lvl);
        logic [2*WIDTH_W-1:0] sq;
        sq = (2*WIDTH_W)'(lvl) * (2*WIDTH_W)'(lvl);
        sq = sq + (2*WIDTH_W)'(255);
        return sq[2*WIDTH_W-1:WIDTH_W];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler that raises a one-cycle tick at terminal count; while stall is
// high it parks at terminal count so no tick is lost or repeated.
module tick_divider #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk_50,
    input  logic rst,
    input  logic run,
    input  logic stall,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_tc;

    always_comb begin
        at_tc = (cnt_q == CNT_TC);
        tick  = run && at_tc && !stall;
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (!at_tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!stall) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_width_sequencer.sv
// Triangle brightness ramp (up, hold, down, hold) delivered over valid/ready to the PWM
// driver. Define PWM_SEQ_GAMMA_EN to emit gamma-corrected widths instead of linear ones.
module pwm_width_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned         TICK_DIV   = 100000,
    parameter int unsigned         STEP       = 1,
    parameter int unsigned         HOLD_TICKS = 0,
    parameter logic [WIDTH_W-1:0]  MIN_WIDTH  = 8'h00,
    parameter logic [WIDTH_W-1:0]  MAX_WIDTH  = 8'hff
) (
    input  logic               clk_50,
    input  logic               rst,
    input  logic               enable,
    output logic [WIDTH_W-1:0] width,
    output logic               width_valid,
    input  logic               width_ready,
    output logic               cycle_done
);

    localparam int unsigned        EXT_W     = WIDTH_W + 1;
    localparam int unsigned        HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [EXT_W-1:0]   STEP_X    = EXT_W'(STEP);
    localparam logic [EXT_W-1:0]   MIN_X     = {1'b0, MIN_WIDTH};
    localparam logic [EXT_W-1:0]   MAX_X     = {1'b0, MAX_WIDTH};
    localparam logic [WIDTH_W-1:0] STEP_N    = WIDTH_W'(STEP);

    seq_state_e         state_q, state_d, state_next;
    logic [WIDTH_W-1:0] level_q, level_d, lvl_next;
    logic [HOLD_W-1:0]  hold_q, hold_d, hold_next;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               valid_q, valid_d;
    logic               done_arm_q, done_arm_d;
    logic               done_q;
    logic [EXT_W-1:0]   sum;
    logic               hit_min;
    logic               run, stall, step;

    assign run   = enable && (state_q != StIdle);
    assign stall = valid_q && !width_ready;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_50 (clk_50),
        .rst    (rst),
        .run    (run),
        .stall  (stall),
        .tick   (step)
    );

    // Ramp arithmetic, evaluated every cycle and committed only on a step.
    always_comb begin
        sum        = {1'b0, level_q} + STEP_X;
        lvl_next   = level_q;
        state_next = state_q;
        hold_next  = hold_q;
        hit_min    = 1'b0;
        unique case (state_q)
            StUp: begin
                if (sum >= MAX_X) begin
                    lvl_next = MAX_WIDTH;
                    if (HOLD_TICKS == 0) begin
                        state_next = StDown;
                    end else begin
                        state_next = StHoldHi;
                        hold_next  = HOLD_INIT;
                    end
                end else begin
                    lvl_next = sum[WIDTH_W-1:0];
                end
            end
            StHoldHi: begin
                if (hold_q == HOLD_W'(1)) state_next = StDown;
                else                      hold_next  = hold_q - HOLD_W'(1);
            end
            StDown: begin
                if ({1'b0, level_q} <= MIN_X + STEP_X) begin
                    lvl_next = MIN_WIDTH;
                    hit_min  = 1'b1;
                    if (HOLD_TICKS == 0) begin
                        state_next = StUp;
                    end else begin
                        state_next = StHoldLo;
                        hold_next  = HOLD_INIT;
                    end
                end else begin
                    lvl_next = level_q - STEP_N;
                end
            end
            StHoldLo: begin
                if (hold_q == HOLD_W'(1)) state_next = StUp;
                else                      hold_next  = hold_q - HOLD_W'(1);
            end
            default: ;
        endcase
    end

    // Enable low wins over a coincident step; a pending word survives until accepted.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        hold_d     = hold_q;
        width_d    = width_q;
        valid_d    = valid_q && !width_ready;
        done_arm_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            level_d = MIN_WIDTH;
            hold_d  = '0;
        end else if (state_q == StIdle) begin
            state_d = StUp;
        end else if (step) begin
            state_d    = state_next;
            level_d    = lvl_next;
            hold_d     = hold_next;
            valid_d    = 1'b1;
            done_arm_d = hit_min;
`ifdef PWM_SEQ_GAMMA_EN
            width_d    = gamma(lvl_next);
`else
            width_d    = lvl_next;
`endif
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            level_q    <= MIN_WIDTH;
            hold_q     <= '0;
            width_q    <= MIN_WIDTH;
            valid_q    <= 1'b0;
            done_arm_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            hold_q     <= hold_d;
            width_q    <= width_d;
            valid_q    <= valid_d;
            done_arm_q <= done_arm_d;
            done_q     <= done_arm_q;
        end
    end

    assign width       = width_q;
    assign width_valid = valid_q;
    assign cycle_done  = done_q;

endmodule
